// File: rtl/program_counter_pkg.sv
// Shared MIPS pipeline definitions: address width and reset vector used by
// the fetch-stage program counter and any other stage that carries a PC.
package program_counter_pkg;

    localparam int unsigned           PC_ADDR_W     = 8;
    localparam logic [PC_ADDR_W-1:0]  PC_RESET_ADDR = 8'h00;

endpackage : program_counter_pkg

// File: rtl/program_counter.sv
// Fetch-stage program counter: a plain register that captures the next-PC
// value computed upstream; it never does arithmetic on the address itself.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int unsigned        ADDR_W     = PC_ADDR_W,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = ADDR_W'(PC_RESET_ADDR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] previous_address,
    output logic [ADDR_W-1:0] instruction_address
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    // Next-state selection: upstream owns all next-PC arithmetic, so load as-is.
    always_comb begin
        pc_d = previous_address;
    end

    // PC state register with asynchronous reset to the reset vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign instruction_address = pc_q;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed reset scenarios plus random loads,
// with expected PC values queued by stimulus and compared by a monitor.
module tb_program_counter;

    localparam logic [7:0] RST_VAL = 8'h00;

    logic       clk;
    logic       reset;
    logic [7:0] previous_address;
    logic [7:0] instruction_address;

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];

    program_counter dut (
        .clk                 (clk),
        .reset               (reset),
        .previous_address    (previous_address),
        .instruction_address (instruction_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a loaded PC equals exactly the address presented at the edge.
    task automatic drive(input logic [7:0] v);
        @(negedge clk);
        previous_address = v;
        exp_q.push_back(v);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #3;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: after every rising edge compare the output with the oldest expectation.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("scoreboard", instruction_address, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] last;
        logic [7:0] r;
        checks = 0;
        errors = 0;

        // Reset at time zero, before any clock edge
        reset = 1'b1;
        previous_address = 8'h00;
        #1;
        check("reset_t0", instruction_address, RST_VAL);
        @(posedge clk);
        #2;
        check("reset_hold_edge", instruction_address, RST_VAL);
        #3;
        reset = 1'b0;  // t = 10 ns
        @(posedge clk);
        #2;
        check("post_release_0", instruction_address, 8'h00);
        @(posedge clk);
        #2;
        check("post_release_1", instruction_address, 8'h00);

        // Stepping sequence and wrap values supplied by upstream
        drive(8'h01);
        drive(8'h02);
        drive(8'h03);
        drive(8'hFF);
        drive(8'h00);
        drive(8'h00);
        drive(8'hA7);
        drive(8'hA7);
        drive(8'h5A);
        wait_drain();
        check("pre_pulse_5a", instruction_address, 8'h5A);

        // Short asynchronous reset pulse between edges
        @(negedge clk);
        previous_address = 8'hC3;
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", instruction_address, RST_VAL);
        #1;
        reset = 1'b0;
        exp_q.push_back(8'hC3);
        wait_drain();

        // Reset held across a rising edge overrides the load
        @(negedge clk);
        previous_address = 8'h77;
        reset = 1'b1;
        #1;
        check("reset_mid_op", instruction_address, RST_VAL);
        @(posedge clk);
        #2;
        check("reset_override", instruction_address, RST_VAL);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #2;
        check("first_edge_after_release", instruction_address, 8'h77);

        // Input glitches between edges must not reach the output
        for (int i = 0; i < 4; i++) begin
            last = instruction_address;
            @(negedge clk);
            previous_address = 8'(8'h10 + 8'(i));
            #1;
            check("glitch_a", instruction_address, last);
            previous_address = 8'(8'hE0 - 8'(i));
            #2;
            check("glitch_b", instruction_address, last);
            r = 8'($urandom);
            previous_address = r;
            exp_q.push_back(r);
            wait_drain();
        end

        // Random loads, including repeats of the current value
        for (int i = 0; i < 40; i++) begin
            r = 8'($urandom);
            drive(r);
            if ($urandom_range(0, 3) == 0) begin
                drive(r);
            end
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_program_counter
